// File: rtl/wrr_req_arbiter_if.sv
// Bundle of requester, WRR-engine and status signals around wrr_req_arbiter.
// slave = arbiter view, master = surrounding enqueue logic / engine view.
interface wrr_req_arbiter_if #(
  parameter int NUM_REQ      = 4,
  parameter int CLASS_WIDTH  = 5,
  parameter int WEIGHT_WIDTH = 16,
  parameter int RESULT_WIDTH = 32
);
  logic [NUM_REQ-1:0]              in_valid;
  logic [NUM_REQ-1:0]              in_ready;
  logic [NUM_REQ*CLASS_WIDTH-1:0]  in_class_id;
  logic [NUM_REQ*WEIGHT_WIDTH-1:0] in_weight;
  logic                            eng_req_valid;
  logic [CLASS_WIDTH-1:0]          eng_req_class_id;
  logic [WEIGHT_WIDTH-1:0]         eng_req_class_weight;
  logic                            eng_resp_valid;
  logic [RESULT_WIDTH-1:0]         eng_resp_data;
  logic [NUM_REQ-1:0]              out_resp_valid;
  logic [RESULT_WIDTH-1:0]         out_resp_data;
  logic                            err_orphan;
  logic [31:0]                     perf_grant_cnt;
  logic [31:0]                     perf_hazard_cnt;

  modport slave (
    input  in_valid, in_class_id, in_weight, eng_resp_valid, eng_resp_data,
    output in_ready, eng_req_valid, eng_req_class_id, eng_req_class_weight,
           out_resp_valid, out_resp_data, err_orphan, perf_grant_cnt, perf_hazard_cnt
  );

  modport master (
    output in_valid, in_class_id, in_weight, eng_resp_valid, eng_resp_data,
    input  in_ready, eng_req_valid, eng_req_class_id, eng_req_class_weight,
           out_resp_valid, out_resp_data, err_orphan, perf_grant_cnt, perf_hazard_cnt
  );
endinterface

// File: rtl/wrr_req_arbiter.sv
// Round-robin front end sharing one WRR tag engine among NUM_REQ ports, with class-hazard
// blocking and response routing. Define WRR_ARB_PERF_CNT_EN to build the perf counters.
module wrr_req_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int PORT_WIDTH     = 2,
  parameter int CLASS_WIDTH    = 5,
  parameter int WEIGHT_WIDTH   = 16,
  parameter int RESULT_WIDTH   = 32,
  parameter int ENGINE_LATENCY = 3,
  parameter int HAZARD_DEPTH   = 2
) (
  input logic              clk,
  input logic              rstn,
  wrr_req_arbiter_if.slave bus
);
  localparam int TAG_DEPTH = ENGINE_LATENCY + 1;
  localparam int TAG_OUT   = TAG_DEPTH - 1;

  logic [NUM_REQ-1:0]      eligible;
  logic [NUM_REQ-1:0]      grant_oh;
  logic                    grant_any;
  logic [PORT_WIDTH-1:0]   grant_port;
  logic [CLASS_WIDTH-1:0]  grant_class;
  logic [WEIGHT_WIDTH-1:0] grant_weight;
  int                      sel_dist;
  int                      sel_best;

  logic [PORT_WIDTH-1:0]   ptr_q, ptr_d;
  logic [HAZARD_DEPTH-1:0] haz_vld_q, haz_vld_d;
  logic [CLASS_WIDTH-1:0]  haz_class_q [HAZARD_DEPTH];
  logic [CLASS_WIDTH-1:0]  haz_class_d [HAZARD_DEPTH];
  logic [TAG_DEPTH-1:0]    tag_vld_q, tag_vld_d;
  logic [PORT_WIDTH-1:0]   tag_port_q [TAG_DEPTH];
  logic [PORT_WIDTH-1:0]   tag_port_d [TAG_DEPTH];

  logic                    eng_req_valid_q, eng_req_valid_d;
  logic [CLASS_WIDTH-1:0]  eng_req_class_id_q, eng_req_class_id_d;
  logic [WEIGHT_WIDTH-1:0] eng_req_class_weight_q, eng_req_class_weight_d;
  logic [NUM_REQ-1:0]      out_resp_valid_q, out_resp_valid_d;
  logic [RESULT_WIDTH-1:0] out_resp_data_q, out_resp_data_d;
  logic                    err_orphan_q, err_orphan_d;
  logic                    resp_hit;
  logic                    resp_orphan;

  // A port is blocked while its class is still inside the engine's read-modify-write window.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible[i] = rstn & bus.in_valid[i];
      for (int h = 0; h < HAZARD_DEPTH; h++) begin
        if (haz_vld_q[h] && (haz_class_q[h] == bus.in_class_id[i*CLASS_WIDTH +: CLASS_WIDTH]))
          eligible[i] = 1'b0;
      end
    end
  end

  // Pick the eligible port with the smallest wrapped distance from ptr.
  always_comb begin
    grant_any  = 1'b0;
    grant_port = '0;
    sel_dist   = 0;
    sel_best   = NUM_REQ;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_dist = i - int'(ptr_q);
      if (sel_dist < 0) sel_dist = sel_dist + NUM_REQ;
      if (eligible[i] && (sel_dist < sel_best)) begin
        sel_best   = sel_dist;
        grant_any  = 1'b1;
        grant_port = PORT_WIDTH'(i);
      end
    end
  end

  always_comb begin
    grant_oh     = '0;
    grant_class  = '0;
    grant_weight = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      grant_oh[i] = grant_any && (grant_port == PORT_WIDTH'(i));
      if (grant_oh[i]) begin
        grant_class  = bus.in_class_id[i*CLASS_WIDTH +: CLASS_WIDTH];
        grant_weight = bus.in_weight[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
      end
    end
  end

  assign bus.in_ready = grant_oh;

  always_comb begin
    ptr_d = ptr_q;
    if (grant_any)
      ptr_d = (grant_port == PORT_WIDTH'(NUM_REQ - 1)) ? '0 : grant_port + PORT_WIDTH'(1);
  end

  always_comb begin
    haz_vld_d      = '0;
    haz_vld_d[0]   = grant_any;
    haz_class_d[0] = grant_class;
    for (int h = 1; h < HAZARD_DEPTH; h++) begin
      haz_vld_d[h]   = haz_vld_q[h-1];
      haz_class_d[h] = haz_class_q[h-1];
    end
  end

  // Tag stage TAG_OUT lines up with the engine response for the same grant.
  always_comb begin
    tag_vld_d     = '0;
    tag_vld_d[0]  = grant_any;
    tag_port_d[0] = grant_port;
    for (int t = 1; t < TAG_DEPTH; t++) begin
      tag_vld_d[t]  = tag_vld_q[t-1];
      tag_port_d[t] = tag_port_q[t-1];
    end
  end

  always_comb begin
    eng_req_valid_d        = grant_any;
    eng_req_class_id_d     = eng_req_class_id_q;
    eng_req_class_weight_d = eng_req_class_weight_q;
    if (grant_any) begin
      eng_req_class_id_d     = grant_class;
      eng_req_class_weight_d = grant_weight;
    end
  end

  assign resp_hit    = bus.eng_resp_valid &  tag_vld_q[TAG_OUT];
  assign resp_orphan = bus.eng_resp_valid & ~tag_vld_q[TAG_OUT];

  always_comb begin
    out_resp_valid_d = '0;
    out_resp_data_d  = out_resp_data_q;
    if (resp_hit) begin
      for (int i = 0; i < NUM_REQ; i++)
        out_resp_valid_d[i] = (tag_port_q[TAG_OUT] == PORT_WIDTH'(i));
      out_resp_data_d = bus.eng_resp_data;
    end
    err_orphan_d = err_orphan_q | resp_orphan;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      ptr_q                  <= '0;
      haz_vld_q              <= '0;
      tag_vld_q              <= '0;
      eng_req_valid_q        <= 1'b0;
      eng_req_class_id_q     <= '0;
      eng_req_class_weight_q <= '0;
      out_resp_valid_q       <= '0;
      out_resp_data_q        <= '0;
      err_orphan_q           <= 1'b0;
      for (int h = 0; h < HAZARD_DEPTH; h++) haz_class_q[h] <= '0;
      for (int t = 0; t < TAG_DEPTH; t++)    tag_port_q[t]  <= '0;
    end else begin
      ptr_q                  <= ptr_d;
      haz_vld_q              <= haz_vld_d;
      tag_vld_q              <= tag_vld_d;
      eng_req_valid_q        <= eng_req_valid_d;
      eng_req_class_id_q     <= eng_req_class_id_d;
      eng_req_class_weight_q <= eng_req_class_weight_d;
      out_resp_valid_q       <= out_resp_valid_d;
      out_resp_data_q        <= out_resp_data_d;
      err_orphan_q           <= err_orphan_d;
      for (int h = 0; h < HAZARD_DEPTH; h++) haz_class_q[h] <= haz_class_d[h];
      for (int t = 0; t < TAG_DEPTH; t++)    tag_port_q[t]  <= tag_port_d[t];
    end
  end

  assign bus.eng_req_valid        = eng_req_valid_q;
  assign bus.eng_req_class_id     = eng_req_class_id_q;
  assign bus.eng_req_class_weight = eng_req_class_weight_q;
  assign bus.out_resp_valid       = out_resp_valid_q;
  assign bus.out_resp_data        = out_resp_data_q;
  assign bus.err_orphan           = err_orphan_q;

`ifdef WRR_ARB_PERF_CNT_EN
  logic [31:0] perf_grant_cnt_q, perf_grant_cnt_d;
  logic [31:0] perf_hazard_cnt_q, perf_hazard_cnt_d;

  // Counters wrap naturally; a stall is any cycle with a request pending and no grant.
  always_comb begin
    perf_grant_cnt_d  = perf_grant_cnt_q + {31'd0, grant_any};
    perf_hazard_cnt_d = perf_hazard_cnt_q + {31'd0, (|bus.in_valid) & ~grant_any};
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      perf_grant_cnt_q  <= '0;
      perf_hazard_cnt_q <= '0;
    end else begin
      perf_grant_cnt_q  <= perf_grant_cnt_d;
      perf_hazard_cnt_q <= perf_hazard_cnt_d;
    end
  end

  assign bus.perf_grant_cnt  = perf_grant_cnt_q;
  assign bus.perf_hazard_cnt = perf_hazard_cnt_q;
`else
  assign bus.perf_grant_cnt  = '0;
  assign bus.perf_hazard_cnt = '0;
`endif

endmodule

// File: doc/wrr_req_arbiter.md
# wrr_req_arbiter

Shares one WRR tag-calculation engine among NUM_REQ ingress requesters. Each cycle it grants at most one request round-robin and drives the engine's request port from a register. It blocks any request whose class is still in flight in the engine's read-modify-write window, and routes each engine response back to the port that issued it. It sits between the per-port enqueue logic and the WRR engine, upstream of PIFO insertion.

## Interface
- NUM_REQ, 4: number of requester ports (2..16).
- PORT_WIDTH, 2: width of port index, $clog2(NUM_REQ).
- CLASS_WIDTH, 5: class id width.
- WEIGHT_WIDTH, 16: class weight width.
- RESULT_WIDTH, 32: engine result width.
- ENGINE_LATENCY, 3: cycles from engine req_valid to engine resp_valid.
- HAZARD_DEPTH, 2: cycles after a grant during which the same class is blocked.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset, synchronous, active-low.
- in_valid  in  NUM_REQ  per-port request valid.
- in_ready  out  NUM_REQ  per-port grant, one-hot or zero.
- in_class_id  in  NUM_REQ*CLASS_WIDTH  per-port class, port i at [i*CLASS_WIDTH +: CLASS_WIDTH].
- in_weight  in  NUM_REQ*WEIGHT_WIDTH  per-port class weight.
- eng_req_valid  out  1  engine request.
- eng_req_class_id  out  CLASS_WIDTH  engine class.
- eng_req_class_weight  out  WEIGHT_WIDTH  engine weight.
- eng_resp_valid  in  1  engine result valid.
- eng_resp_data  in  RESULT_WIDTH  engine result.
- out_resp_valid  out  NUM_REQ  one-hot response strobe.
- out_resp_data  out  RESULT_WIDTH  response data, shared by all ports.
- err_orphan  out  1  sticky flag: an engine response arrived with no matching tag.
- perf_grant_cnt  out  32  grant counter (see Configuration).
- perf_hazard_cnt  out  32  hazard-stall counter (see Configuration).

## Operation
- Port i is eligible when in_valid[i]=1 and its class differs from every valid entry in the hazard history. The history holds the classes granted in the previous HAZARD_DEPTH cycles.
- Round-robin pointer ptr: the search starts at ptr and wraps modulo NUM_REQ. The first eligible port p is granted: in_ready[p]=1 in the same cycle, combinational. Then ptr <= (p+1) mod NUM_REQ.
- With no grant, ptr holds.
- Requester handshake: in_valid and data are held stable until in_ready. Dropping in_valid before grant is legal and has no side effects.
- The granted class and weight are registered onto the eng_req_* outputs in the following cycle, with eng_req_valid=1. With no grant, eng_req_valid=0 and the class/weight outputs hold their values.
- The granted port id enters a tag shift register of depth ENGINE_LATENCY+1, together with a valid bit.
- On eng_resp_valid with a valid tag at the output stage, out_resp_valid[tag] and out_resp_data are registered one cycle later.
- On eng_resp_valid with no valid tag, the response is dropped and err_orphan is set to 1. err_orphan clears only on reset.
- A valid tag with eng_resp_valid=0 is dropped silently; the engine never skips a response.
- Simultaneous same-class requests on two ports: the port nearer ptr wins. The other port is blocked for HAZARD_DEPTH cycles, then granted normally.
- Reset mid-operation: the tag pipe, hazard history, ptr (to 0) and all outputs are cleared. In-flight responses are lost.

## Timing
- Reset values: in_ready=0, eng_req_valid=0, eng_req_class_id=0, eng_req_class_weight=0, out_resp_valid=0, out_resp_data=0, err_orphan=0, perf counters=0.
- Grant at cycle g produces eng_req_valid at g+1, eng_resp_valid at g+4, and out_resp_valid at g+5.
- For a class granted at g, the same class is blocked at g+1 and g+2 and is grantable at g+3.
- Peak throughput is one grant per cycle when consecutive grants use distinct classes.

## Configuration
- WRR_ARB_PERF_CNT_EN defined: both 32-bit counters are enabled. They wrap at 2^32-1 to 0.
  - perf_grant_cnt increments on each grant.
  - perf_hazard_cnt increments on each cycle where |in_valid=1 but no grant occurs.
- WRR_ARB_PERF_CNT_EN undefined: no counter flops are built, and both outputs are constant 0.

## Test plan
- Single port 0, class 3, weight 5, granted at cycle 10 -> eng_req_valid at 11 with class 3 and weight 5. Engine returns 0x8000_1000 at 14 -> out_resp_valid=4'b0001 with data 0x8000_1000 at 15.
- All four ports valid, distinct classes 1,2,3,4, ptr=0 -> grants in port order 0,1,2,3 on four consecutive cycles, then ptr=0.
- Ports 0 and 1 both class 7, ptr=0 -> port 0 granted at g, port 1 granted at g+3. With the counters enabled, perf_hazard_cnt=2.
- Port 2 holds class 5 continuously -> grants at g, g+3, g+6. Responses return only to port 2, in order.
- Inject eng_resp_valid with no outstanding tag -> err_orphan=1 with no out_resp_valid. A subsequent normal transaction still completes.
- Assert rstn=0 for one cycle while 3 requests are in flight -> every output returns to its reset value, and later engine responses set err_orphan.
